// File: rtl/picomips_pkg.sv
// Shared picoMips definitions: opcode map, instruction field widths, sequencer states.
// Latency: none (declarations only). Backpressure: n/a.
package picomips_pkg;

    localparam int OPCODE_W  = 6;
    localparam int OPERAND_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_MULI = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_LD   = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_ST   = 6'd7;
    localparam logic [OPCODE_W-1:0] OP_HEI  = 6'd8;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_t;

    // HEI operand bit 0 selects the awaited level: 0 waits for SW8=1, 1 waits for SW8=0.
    function automatic logic hei_cond_met(input logic sw8_level, input logic operand_lsb);
        return sw8_level == ~operand_lsb;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous inputs, reset to 0.
// Latency: 2 clk cycles. Backpressure: none.
// (no internal handshake)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// picoMips program counter and fetch/exec sequencer; optional single-step via `SINGLE_STEP_EN.
// Latency: 2 cycles per retired instruction (fetch, exec). Backpressure: stalls in S_WAIT on unmet HEI
// (and, with SINGLE_STEP_EN, in S_EXEC until a Step rising edge).
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int INSTR_W    = 10,
    parameter int RESET_ADDR = 0,
    parameter int PROG_END   = 27
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               SW8,
`ifdef SINGLE_STEP_EN
    input  logic               Step,
`endif
    output logic [ADDR_W-1:0]  Addr,
    output logic               ExecEn,
    output logic               Waiting
);

    seq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   next_pc;
    logic [OPCODE_W-1:0] opcode;
    logic                sw8_s;
    logic                is_hei;
    logic                hei_met;
    logic                step_go;
    logic                unused_operand;

    sync_2ff u_sw8_sync (
        .clk   (Clock),
        .rst_n (nReset),
        .d     (SW8),
        .q     (sw8_s)
    );

`ifdef SINGLE_STEP_EN
    logic step_s;
    logic step_d;

    sync_2ff u_step_sync (
        .clk   (Clock),
        .rst_n (nReset),
        .d     (Step),
        .q     (step_s)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            step_d <= 1'b0;
        end else begin
            step_d <= step_s;
        end
    end

    assign step_go = step_s & ~step_d;
`else
    assign step_go = 1'b1;
`endif

    assign opcode         = Instruction[INSTR_W-1 -: OPCODE_W];
    assign is_hei         = (opcode == OP_HEI);
    assign hei_met        = hei_cond_met(sw8_s, Instruction[0]);
    assign unused_operand = ^Instruction[OPERAND_W-1:1];

    // Wrap explicitly at PROG_END; the add wraps naturally when PROG_END is all-ones.
    assign next_pc = (addr_q == ADDR_W'(PROG_END)) ? ADDR_W'(RESET_ADDR)
                                                    : addr_q + ADDR_W'(1);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_FETCH;
            addr_q  <= ADDR_W'(RESET_ADDR);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ExecEn  = 1'b0;
        Waiting = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (step_go) begin
                    if (!is_hei) begin
                        ExecEn  = 1'b1;
                        addr_d  = next_pc;
                        state_d = S_FETCH;
                    end else if (hei_met) begin
                        addr_d  = next_pc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Memory keeps re-registering mem[Addr], so Instruction is still the HEI here.
                if (hei_met) begin
                    addr_d  = next_pc;
                    state_d = S_FETCH;
                end else begin
                    Waiting = 1'b1;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign Addr = addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: registered program-memory model, ExecEn scoreboard plus directed checks.
module tb_pc_sequencer;
    import picomips_pkg::*;

    logic       Clock  = 1'b0;
    logic       nReset = 1'b0;
    logic       SW8    = 1'b0;
`ifdef SINGLE_STEP_EN
    logic       Step   = 1'b0;
`endif
    logic [9:0] Instruction = '0;
    logic [4:0] Addr;
    logic       ExecEn;
    logic       Waiting;

    logic [9:0] mem [32];
    logic [4:0] exp_q [$];
    logic [4:0] exp_addr;
    logic       prev_exec = 1'b0;
    int         checks    = 0;
    int         failures  = 0;

    always #5 Clock = ~Clock;

    always @(posedge Clock) Instruction <= mem[Addr];

    pc_sequencer dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .Instruction (Instruction),
        .SW8         (SW8),
`ifdef SINGLE_STEP_EN
        .Step        (Step),
`endif
        .Addr        (Addr),
        .ExecEn      (ExecEn),
        .Waiting     (Waiting)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] ins(input logic [5:0] op, input logic [3:0] opnd);
        return {op, opnd};
    endfunction

    task automatic fill_add();
        for (int i = 0; i < 32; i++) mem[i] = ins(OP_ADD, 4'(i));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        nReset = 1'b0;
        repeat (3) @(negedge Clock);
        nReset = 1'b1;
    endtask

    // Scoreboard monitor: each ExecEn must match the next expected retire address.
    always @(negedge Clock) begin
        if (ExecEn) begin
            check("exec_back_to_back", int'(prev_exec), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL exec_unexpected: ExecEn at Addr=%0d, expected none", Addr);
            end else begin
                exp_addr = exp_q.pop_front();
                check("exec_addr", int'(Addr), int'(exp_addr));
            end
        end
        prev_exec = ExecEn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_add();
`ifdef SINGLE_STEP_EN
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("step_frozen_addr", int'(Addr), 0);
            check("step_frozen_exec", int'(ExecEn), 0);
        end
        for (int k = 0; k < 2; k++) begin
            Step = 1'b1;
            exp_q.push_back(5'(k));
            cyc(2);
            check("step_exec", int'(ExecEn), 1);
            cyc(4);
            check("step_addr_inc", int'(Addr), k + 1);
            check("step_single_exec", int'(ExecEn), 0);
            Step = 1'b0;
            cyc(3);
        end
`else
        // Reset and straight-line program; addr 4 parks the run on an HEI.
        mem[4] = ins(OP_HEI, 4'b0000);
        SW8 = 1'b0;
        @(negedge Clock);
        nReset = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_addr", int'(Addr), 0);
        check("reset_exec", int'(ExecEn), 0);
        check("reset_waiting", int'(Waiting), 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(5'(i));
        nReset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("line_exec_addr", int'(Addr), i);
            check("line_exec", int'(ExecEn), 1);
            cyc(1);
            check("line_fetch_addr", int'(Addr), i + 1);
            check("line_fetch_exec", int'(ExecEn), 0);
        end
        cyc(2);
        check("line_park_waiting", int'(Waiting), 1);
        check("line_park_addr", int'(Addr), 4);

        // HEI stall and release, both operand polarities, upper operand bits ignored.
        fill_add();
        mem[0] = ins(OP_HEI, 4'b0000);
        mem[2] = ins(OP_HEI, 4'b0001);
        mem[3] = ins(OP_HEI, 4'b1110);
        SW8 = 1'b0;
        do_reset();
        cyc(1);
        check("hei_exec_waiting", int'(Waiting), 0);
        check("hei_exec_no_exec", int'(ExecEn), 0);
        cyc(1);
        check("hei_wait_enter", int'(Waiting), 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("hei_stall_waiting", int'(Waiting), 1);
            check("hei_stall_addr", int'(Addr), 0);
        end
        SW8 = 1'b1;
        exp_q.push_back(5'd1);
        cyc(1);
        check("hei_sync_lat1", int'(Waiting), 1);
        cyc(1);
        check("hei_release_waiting", int'(Waiting), 0);
        check("hei_release_addr", int'(Addr), 0);
        check("hei_release_no_exec", int'(ExecEn), 0);
        cyc(1);
        check("hei_next_addr", int'(Addr), 1);
        cyc(1);
        check("hei_next_exec", int'(ExecEn), 1);
        cyc(4);
        check("hei1_waiting", int'(Waiting), 1);
        check("hei1_addr", int'(Addr), 2);
        SW8 = 1'b0;
        cyc(2);
        check("hei1_release", int'(Waiting), 0);
        cyc(3);
        check("hei_ign_waiting", int'(Waiting), 1);
        check("hei_ign_addr", int'(Addr), 3);

        // Wrap from PROG_END back to the reset address.
        fill_add();
        SW8 = 1'b0;
        for (int i = 0; i < 28; i++) exp_q.push_back(5'(i));
        do_reset();
        cyc(54);
        check("wrap_at_end", int'(Addr), 27);
        mem[1] = ins(OP_HEI, 4'b0000);
        cyc(1);
        check("wrap_exec_end", int'(ExecEn), 1);
        cyc(1);
        check("wrap_addr", int'(Addr), 0);
        exp_q.push_back(5'd0);
        cyc(4);
        check("wrap_park_addr", int'(Addr), 1);
        check("wrap_park_waiting", int'(Waiting), 1);

        // Asynchronous reset while stalled.
        fill_add();
        mem[7] = ins(OP_HEI, 4'b0001);
        SW8 = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(5'(i));
        do_reset();
        cyc(16);
        check("stall7_waiting", int'(Waiting), 1);
        check("stall7_addr", int'(Addr), 7);
        mem[1] = ins(OP_HEI, 4'b0001);
        nReset = 1'b0;
        #1;
        check("midreset_addr", int'(Addr), 0);
        check("midreset_waiting", int'(Waiting), 0);
        check("midreset_exec", int'(ExecEn), 0);
        #3;
        nReset = 1'b1;
        exp_q.push_back(5'd0);
        @(negedge Clock);
        check("postreset_exec", int'(ExecEn), 1);
        check("postreset_addr", int'(Addr), 0);
        cyc(3);
        check("postreset_park_waiting", int'(Waiting), 1);
        check("postreset_park_addr", int'(Addr), 1);
`endif
        cyc(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
